bp_me_nonsynth_lce_tr_player: RTL and testbench

//  Trace-replay master for one LCE in ME testbenches; drives the LCE trace-replay port, the opposite end of the LCE trace monitor.

---
 rtl/bp_me_nonsynth_pkg.sv | 40 ++++
 rtl/bp_me_nonsynth_tr_cmp.sv | 19 +
 rtl/bp_me_nonsynth_lce_tr_player.sv | 177 +++++++++++++++++
 tb/tb_bp_me_nonsynth_lce_tr_player.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_nonsynth_pkg.sv
// Shared types for the LCE trace-replay player: op codes, FSM states and the
// trace-ring packet layout {uncached, paddr, data}.
package bp_me_nonsynth_pkg;

    localparam int paddr_width_p  = 40;
    localparam int dword_width_p  = 64;
    localparam int lce_id_width_p = 4;

    typedef enum logic [3:0] {
        e_tr_op_nop     = 4'd0,
        e_tr_op_send    = 4'd1,
        e_tr_op_recv    = 4'd2,
        e_tr_op_recv_nd = 4'd3,
        e_tr_op_wait    = 4'd4,
        e_tr_op_finish  = 4'd5
    } bp_me_nonsynth_tr_op_e;

    typedef enum logic [2:0] {
        e_st_idle  = 3'd0,
        e_st_fetch = 3'd1,
        e_st_send  = 3'd2,
        e_st_recv  = 3'd3,
        e_st_wait  = 3'd4,
        e_st_done  = 3'd5,
        e_st_error = 3'd6
    } bp_me_nonsynth_tr_state_e;

    typedef struct packed {
        logic                     uncached;
        logic [paddr_width_p-1:0] paddr;
        logic [dword_width_p-1:0] data;
    } bp_me_nonsynth_lce_tr_pkt_s;

    localparam int tr_ring_width_lp = $bits(bp_me_nonsynth_lce_tr_pkt_s);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/bp_me_nonsynth_tr_cmp.sv
// Field compare of an expected vs. returned trace packet; data bits are only
// compared where the mask is set.
module bp_me_nonsynth_tr_cmp
    import bp_me_nonsynth_pkg::*;
(
    input  bp_me_nonsynth_lce_tr_pkt_s i_exp,
    input  bp_me_nonsynth_lce_tr_pkt_s i_act,
    input  logic [dword_width_p-1:0]   i_data_mask,
    output logic                       o_match
);

    // match when uncached and paddr agree and all unmasked data bits agree
    always_comb begin
        o_match = (i_exp.uncached == i_act.uncached)
               && (i_exp.paddr == i_act.paddr)
               && (((i_exp.data ^ i_act.data) & i_data_mask) == {dword_width_p{1'b0}});
    end

endmodule

// File: rtl/bp_me_nonsynth_lce_tr_player.sv
// Trace-replay master for one LCE: fetches ops from a trace ROM, issues command
// packets, checks responses, and reports done/error with a saturating count.
module bp_me_nonsynth_lce_tr_player
    import bp_me_nonsynth_pkg::*;
#(
    parameter  int rom_addr_width_p  = 10,
    parameter  int timeout_p         = 4096,
    localparam int rom_data_width_lp = 4 + tr_ring_width_lp
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         en_i,
    input  logic [lce_id_width_p-1:0]    lce_id_i,
    output logic [rom_addr_width_p-1:0]  rom_addr_o,
    input  logic [rom_data_width_lp-1:0] rom_data_i,
    output logic [tr_ring_width_lp-1:0]  tr_pkt_o,
    output logic                         tr_pkt_v_o,
    input  logic                         tr_pkt_yumi_i,
    input  logic [tr_ring_width_lp-1:0]  tr_pkt_i,
    input  logic                         tr_pkt_v_i,
    output logic                         tr_pkt_ready_o,
    output logic                         done_o,
    output logic                         error_o,
    output logic [15:0]                  err_cnt_o
);

    localparam int to_width_lp = $clog2(timeout_p + 1);
    localparam logic [to_width_lp-1:0]      to_last_lp  = to_width_lp'(timeout_p - 1);
    localparam logic [to_width_lp-1:0]      to_one_lp   = to_width_lp'(1);
    localparam logic [rom_addr_width_p-1:0] addr_one_lp = rom_addr_width_p'(1);

    bp_me_nonsynth_tr_state_e   r_state;
    bp_me_nonsynth_lce_tr_pkt_s r_pkt;
    logic [rom_addr_width_p-1:0] r_addr;
    logic [15:0]                 r_wait_cnt;
    logic [to_width_lp-1:0]      r_to_cnt;
    logic [15:0]                 r_err_cnt;
    logic                        r_cmp_data;
    logic                        r_v;
    logic                        r_ready;
    logic                        r_done;
    logic                        r_error;

    logic [3:0]                  w_rom_op;
    bp_me_nonsynth_lce_tr_pkt_s  w_rom_pkt;
    bp_me_nonsynth_lce_tr_pkt_s  w_resp_pkt;
    logic [rom_addr_width_p-1:0] w_addr_nxt;
    logic                        w_match;
    logic                        w_unused_lce_id;

    assign w_rom_op        = rom_data_i[rom_data_width_lp-1 -: 4];
    assign w_rom_pkt       = rom_data_i[tr_ring_width_lp-1:0];
    assign w_resp_pkt      = tr_pkt_i;
    assign w_addr_nxt      = r_addr + addr_one_lp;
    assign w_unused_lce_id = ^lce_id_i;

    bp_me_nonsynth_tr_cmp u_cmp (
        .i_exp       (r_pkt),
        .i_act       (w_resp_pkt),
        .i_data_mask ({dword_width_p{r_cmp_data}}),
        .o_match     (w_match)
    );

    // replay FSM; every output is a flop updated alongside the state
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state    <= e_st_idle;
            r_pkt      <= '{uncached: 1'b0, paddr: {paddr_width_p{1'b0}}, data: {dword_width_p{1'b0}}};
            r_addr     <= {rom_addr_width_p{1'b0}};
            r_wait_cnt <= 16'd0;
            r_to_cnt   <= {to_width_lp{1'b0}};
            r_err_cnt  <= 16'd0;
            r_cmp_data <= 1'b0;
            r_v        <= 1'b0;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                e_st_idle: begin
                    if (en_i) r_state <= e_st_fetch;
                end
                e_st_fetch: begin
                    r_pkt <= w_rom_pkt;
                    case (w_rom_op)
                        e_tr_op_nop: r_addr <= w_addr_nxt;
                        e_tr_op_send: begin
                            r_v      <= 1'b1;
                            r_to_cnt <= {to_width_lp{1'b0}};
                            r_state  <= e_st_send;
                        end
                        e_tr_op_recv, e_tr_op_recv_nd: begin
                            r_ready    <= 1'b1;
                            r_to_cnt   <= {to_width_lp{1'b0}};
                            r_cmp_data <= (w_rom_op == e_tr_op_recv);
                            r_state    <= e_st_recv;
                        end
                        e_tr_op_wait: begin
                            // the FETCH cycle is the first wait cycle, so load n-1
                            if (w_rom_pkt.data[15:0] == 16'd0) begin
                                r_addr <= w_addr_nxt;
                            end else begin
                                r_wait_cnt <= w_rom_pkt.data[15:0] - 16'd1;
                                r_state    <= e_st_wait;
                            end
                        end
                        e_tr_op_finish: begin
                            r_done  <= 1'b1;
                            r_state <= e_st_done;
                        end
                        default: begin
                            r_error <= 1'b1;
                            r_state <= e_st_error;
                        end
                    endcase
                end
                e_st_send: begin
                    if (tr_pkt_yumi_i) begin
                        r_v     <= 1'b0;
                        r_addr  <= w_addr_nxt;
                        r_state <= e_st_fetch;
                    end else if (r_to_cnt == to_last_lp) begin
                        r_v       <= 1'b0;
                        r_error   <= 1'b1;
                        r_err_cnt <= sat_inc16(r_err_cnt);
                        r_state   <= e_st_error;
                    end else begin
                        r_to_cnt <= r_to_cnt + to_one_lp;
                    end
                end
                e_st_recv: begin
                    if (tr_pkt_v_i) begin
                        r_ready <= 1'b0;
                        r_addr  <= w_addr_nxt;
                        r_state <= e_st_fetch;
                        if (!w_match) begin
                            r_error   <= 1'b1;
                            r_err_cnt <= sat_inc16(r_err_cnt);
                        end
                    end else if (r_to_cnt == to_last_lp) begin
                        r_ready   <= 1'b0;
                        r_error   <= 1'b1;
                        r_err_cnt <= sat_inc16(r_err_cnt);
                        r_state   <= e_st_error;
                    end else begin
                        r_to_cnt <= r_to_cnt + to_one_lp;
                    end
                end
                e_st_wait: begin
                    if (r_wait_cnt == 16'd0) begin
                        r_addr  <= w_addr_nxt;
                        r_state <= e_st_fetch;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 16'd1;
                    end
                end
                e_st_done: r_state <= e_st_done;
                e_st_error: r_state <= e_st_error;
                default: begin
                    r_v     <= 1'b0;
                    r_ready <= 1'b0;
                    r_error <= 1'b1;
                    r_state <= e_st_error;
                end
            endcase
        end
    end

    assign rom_addr_o     = r_addr;
    assign tr_pkt_o       = r_pkt;
    assign tr_pkt_v_o     = r_v;
    assign tr_pkt_ready_o = r_ready;
    assign done_o         = r_done;
    assign error_o        = r_error;
    assign err_cnt_o      = r_err_cnt;

endmodule

// File: tb/tb_bp_me_nonsynth_lce_tr_player.sv
// Directed bench for the LCE trace-replay player; the LCE side is driven by hand
// and the trace ROM is a bench-owned array read combinationally.
module tb_bp_me_nonsynth_lce_tr_player;
    import bp_me_nonsynth_pkg::*;

    localparam int AW = 10;
    localparam int PW = tr_ring_width_lp;
    localparam int RW = 4 + PW;

    logic                      clk;
    logic                      rst_n;
    logic                      en;
    logic [lce_id_width_p-1:0] lce_id;
    logic [AW-1:0]             rom_addr;
    logic [RW-1:0]             rom_data;
    logic [PW-1:0]             pkt_o;
    logic                      pkt_v_o;
    logic                      yumi;
    logic [PW-1:0]             pkt_i;
    logic                      pkt_v_i;
    logic                      ready_o;
    logic                      done;
    logic                      error;
    logic [15:0]               err_cnt;

    logic [RW-1:0] rom [0:(1<<AW)-1];
    assign rom_data = rom[rom_addr];

    int n_vec  = 0;
    int n_fail = 0;

    bp_me_nonsynth_lce_tr_player #(.rom_addr_width_p(AW), .timeout_p(16)) dut (
        .clk_i          (clk),
        .reset_n_i      (rst_n),
        .en_i           (en),
        .lce_id_i       (lce_id),
        .rom_addr_o     (rom_addr),
        .rom_data_i     (rom_data),
        .tr_pkt_o       (pkt_o),
        .tr_pkt_v_o     (pkt_v_o),
        .tr_pkt_yumi_i  (yumi),
        .tr_pkt_i       (pkt_i),
        .tr_pkt_v_i     (pkt_v_i),
        .tr_pkt_ready_o (ready_o),
        .done_o         (done),
        .error_o        (error),
        .err_cnt_o      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pk(input logic unc, input logic [paddr_width_p-1:0] pa,
                                         input logic [dword_width_p-1:0] d);
        return {unc, pa, d};
    endfunction

    function automatic logic [RW-1:0] rop(input logic [3:0] o, input logic [PW-1:0] p);
        return {o, p};
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clr_rom();
        for (int i = 0; i < (1 << AW); i++) rom[i] = {RW{1'b0}};
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {pkt_o, rom_addr, pkt_v_o, ready_o, done, error, err_cnt}, 160'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; yumi = 1'b0; pkt_v_i = 1'b0; pkt_i = {PW{1'b0}};
        #1;
        chk_zero("reset_outs");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; yumi = 1'b0; pkt_v_i = 1'b0; pkt_i = {PW{1'b0}};
        lce_id = 4'd3;
        clr_rom();
        #1;
        chk_zero("por_outs");

        // 1: SEND + echoed RECV + FINISH
        clr_rom();
        rom[0] = rop(4'd1, pk(1'b0, 40'h80, 64'hAB));
        rom[1] = rop(4'd2, pk(1'b0, 40'h80, 64'hAB));
        rom[2] = rop(4'd5, {PW{1'b0}});
        do_reset();
        en = 1'b1;
        step();                                       // FETCH SEND
        chk("s1_v_fetch", 160'(pkt_v_o), 160'd0);
        step();                                       // SEND
        chk("s1_v", 160'(pkt_v_o), 160'd1);
        chk("s1_pkt", 160'(pkt_o), 160'(pk(1'b0, 40'h80, 64'hAB)));
        yumi = 1'b1;
        step();                                       // FETCH RECV
        yumi = 1'b0;
        chk("s1_v_drop", 160'(pkt_v_o), 160'd0);
        chk("s1_addr1", 160'(rom_addr), 160'd1);
        step();                                       // RECV
        chk("s1_ready", 160'(ready_o), 160'd1);
        pkt_v_i = 1'b1; pkt_i = pk(1'b0, 40'h80, 64'hAB);
        step();                                       // FETCH FINISH
        pkt_v_i = 1'b0;
        chk("s1_ready_drop", 160'(ready_o), 160'd0);
        step();                                       // DONE
        chk("s1_final", {done, error, err_cnt}, {1'b1, 1'b0, 16'd0});
        chk("s1_addr2", 160'(rom_addr), 160'd2);

        // 2: RECV_ND ignores data, RECV data mismatch, RECV_ND uncached mismatch
        clr_rom();
        rom[0] = rop(4'd3, pk(1'b0, 40'h80, 64'hAB));
        rom[1] = rop(4'd2, pk(1'b0, 40'h80, 64'hAB));
        rom[2] = rop(4'd3, pk(1'b1, 40'h100, 64'h0));
        rom[3] = rop(4'd5, {PW{1'b0}});
        do_reset();
        en = 1'b1;
        step(); step();
        chk("s2_ready0", 160'(ready_o), 160'd1);
        pkt_v_i = 1'b1; pkt_i = pk(1'b0, 40'h80, 64'hAC);
        step();
        pkt_v_i = 1'b0;
        chk("s2_nd_ok", {error, err_cnt}, {1'b0, 16'd0});
        step();
        pkt_v_i = 1'b1; pkt_i = pk(1'b0, 40'h80, 64'hAC);
        step();
        pkt_v_i = 1'b0;
        chk("s2_data_mis", {error, err_cnt}, {1'b1, 16'd1});
        step();
        pkt_v_i = 1'b1; pkt_i = pk(1'b0, 40'h100, 64'h0);
        step();
        pkt_v_i = 1'b0;
        chk("s2_unc_mis", {error, err_cnt}, {1'b1, 16'd2});
        step();
        chk("s2_final", {done, error, err_cnt}, {1'b1, 1'b1, 16'd2});

        // 3: yumi held low 10 cycles while the ROM word changes underneath
        clr_rom();
        rom[0] = rop(4'd1, pk(1'b1, 40'h1234, 64'hDEAD_BEEF));
        rom[1] = rop(4'd5, {PW{1'b0}});
        do_reset();
        en = 1'b1;
        step(); step();
        rom[0] = rop(4'd1, pk(1'b0, 40'h5555, 64'h1));
        for (int i = 0; i < 10; i++) begin
            chk("s3_hold", {pkt_v_o, rom_addr, pkt_o}, {1'b1, 10'd0, pk(1'b1, 40'h1234, 64'hDEAD_BEEF)});
            step();
        end
        yumi = 1'b1;
        step();
        yumi = 1'b0;
        chk("s3_hs", {pkt_v_o, rom_addr}, {1'b0, 10'd1});
        step();
        chk("s3_final", {done, error, pkt_v_o, rom_addr}, {1'b1, 1'b0, 1'b0, 10'd1});

        // 4: RECV with no response times out after 16 cycles
        clr_rom();
        rom[0] = rop(4'd2, pk(1'b0, 40'h80, 64'hAB));
        rom[1] = rop(4'd5, {PW{1'b0}});
        do_reset();
        en = 1'b1;
        step(); step();
        for (int i = 1; i <= 15; i++) step();
        chk("s4_pre_to", {ready_o, error, err_cnt}, {1'b1, 1'b0, 16'd0});
        step();
        chk("s4_to", {ready_o, done, error, err_cnt}, {1'b0, 1'b0, 1'b1, 16'd1});
        pkt_v_i = 1'b1; pkt_i = pk(1'b0, 40'h80, 64'hAB);
        step(); step();
        pkt_v_i = 1'b0;
        chk("s4_terminal", {ready_o, done, error, err_cnt}, {1'b0, 1'b0, 1'b1, 16'd1});

        // 5: NOP, WAIT 0, WAIT 5, SEND -> v rises 7 cycles after the WAIT 5 fetch
        clr_rom();
        rom[0] = rop(4'd0, {PW{1'b0}});
        rom[1] = rop(4'd4, pk(1'b0, 40'h0, 64'd0));
        rom[2] = rop(4'd4, pk(1'b0, 40'h0, 64'd5));
        rom[3] = rop(4'd1, pk(1'b0, 40'h40, 64'h11));
        rom[4] = rop(4'd5, {PW{1'b0}});
        do_reset();
        en = 1'b1;
        step();
        step();
        chk("s5_nop_addr", 160'(rom_addr), 160'd1);
        step();
        chk("s5_wait0_addr", 160'(rom_addr), 160'd2);
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("s5_wait_v", 160'(pkt_v_o), 160'd0);
        end
        chk("s5_wait_addr", 160'(rom_addr), 160'd3);
        step();
        chk("s5_v_rise", {pkt_v_o, pkt_o}, {1'b1, pk(1'b0, 40'h40, 64'h11)});
        yumi = 1'b1;
        step();
        yumi = 1'b0;
        step();
        chk("s5_final", {done, error}, {1'b1, 1'b0});

        // 6: reset mid-SEND, then restart from address 0
        clr_rom();
        rom[0] = rop(4'd1, pk(1'b0, 40'hC0, 64'h77));
        rom[1] = rop(4'd5, {PW{1'b0}});
        do_reset();
        en = 1'b1;
        step(); step();
        chk("s6_in_send", 160'(pkt_v_o), 160'd1);
        rst_n = 1'b0; en = 1'b0;
        #1;
        chk_zero("s6_async_rst");
        step();
        rst_n = 1'b1;
        step(); step();
        chk("s6_idle", {pkt_v_o, rom_addr, done}, {1'b0, 10'd0, 1'b0});
        en = 1'b1;
        step();
        chk("s6_refetch", {pkt_v_o, rom_addr}, {1'b0, 10'd0});
        step();
        chk("s6_resend", {pkt_v_o, pkt_o}, {1'b1, pk(1'b0, 40'hC0, 64'h77)});
        yumi = 1'b1;
        step();
        yumi = 1'b0;
        step();
        chk("s6_final", {done, error, err_cnt}, {1'b1, 1'b0, 16'd0});

        // 7: illegal op lands in ERROR
        clr_rom();
        rom[0] = rop(4'd9, {PW{1'b0}});
        do_reset();
        en = 1'b1;
        step(); step();
        chk("s7_illegal", {done, error, pkt_v_o, ready_o}, {1'b0, 1'b1, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
